// File: rtl/jedro_1_defines.sv
// Shared definitions for the jedro_1 load-store path.
// Holds the data width, access-size encodings, the error-cause and LSU FSM
// state enums, and the alignment check used when a request is accepted.
package jedro_1_defines;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned NUM_BYTES  = DATA_WIDTH / 8;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_BUS      = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } lsu_err_e;

    typedef enum logic [1:0] {
        LSU_IDLE  = 2'd0,
        LSU_ISSUE = 2'd1,
        LSU_WAIT  = 2'd2,
        LSU_RESP  = 2'd3
    } lsu_state_e;

    // Size 3 is reserved and always reported as misaligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = addr_lo[0];
            SZ_WORD: mis = |addr_lo;
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_bus_initiator_if.sv
// Single-stb/ack RAM bus.
//   stb   : one-cycle transaction strobe (initiator)
//   we    : byte-lane write enables, all zero for reads (initiator)
//   addr  : word-aligned byte address (initiator)
//   wdata : lane-replicated write data (initiator)
//   rdata : read data, valid with ack (responder)
//   ack   : transaction complete (responder)
//   err   : transaction failed (responder)
interface lsu_bus_initiator_if;

    logic                                    stb;
    logic [jedro_1_defines::NUM_BYTES-1:0]   we;
    logic [jedro_1_defines::DATA_WIDTH-1:0]  addr;
    logic [jedro_1_defines::DATA_WIDTH-1:0]  wdata;
    logic [jedro_1_defines::DATA_WIDTH-1:0]  rdata;
    logic                                    ack;
    logic                                    err;

    modport master (
        output stb, we, addr, wdata,
        input  rdata, ack, err
    );

    modport slave (
        input  stb, we, addr, wdata,
        output rdata, ack, err
    );

endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering between the core and a 32-bit word bus (combinational).
//   st_size_i/st_addr_lo_i/st_wdata_i : store request, LSB-justified data
//   st_we_o/st_wdata_o                : lane enables and replicated data
//   ld_size_i/ld_addr_lo_i/ld_signed_i: latched load attributes
//   ld_rdata_i                        : raw bus word
//   ld_data_o                         : extracted, sign/zero-extended load data
module lsu_lane_align
    import jedro_1_defines::*;
(
    input  logic [1:0]            st_size_i,
    input  logic [1:0]            st_addr_lo_i,
    input  logic [DATA_WIDTH-1:0] st_wdata_i,
    output logic [NUM_BYTES-1:0]  st_we_o,
    output logic [DATA_WIDTH-1:0] st_wdata_o,
    input  logic [1:0]            ld_size_i,
    input  logic [1:0]            ld_addr_lo_i,
    input  logic                  ld_signed_i,
    input  logic [DATA_WIDTH-1:0] ld_rdata_i,
    output logic [DATA_WIDTH-1:0] ld_data_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store path: data is replicated across lanes so the responder can pick any lane.
    always_comb begin
        st_we_o    = '0;
        st_wdata_o = st_wdata_i;
        case (st_size_i)
            SZ_BYTE: begin
                st_we_o    = 4'b0001 << st_addr_lo_i;
                st_wdata_o = {4{st_wdata_i[7:0]}};
            end
            SZ_HALF: begin
                st_we_o    = st_addr_lo_i[1] ? 4'b1100 : 4'b0011;
                st_wdata_o = {2{st_wdata_i[15:0]}};
            end
            SZ_WORD: st_we_o = 4'b1111;
            default: st_we_o = '0;
        endcase
    end

    // Load path: pick the addressed lane, then extend.
    always_comb begin
        case (ld_addr_lo_i)
            2'd0:    ld_byte = ld_rdata_i[7:0];
            2'd1:    ld_byte = ld_rdata_i[15:8];
            2'd2:    ld_byte = ld_rdata_i[23:16];
            default: ld_byte = ld_rdata_i[31:24];
        endcase
        ld_half = ld_addr_lo_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];

        case (ld_size_i)
            SZ_BYTE: ld_data_o = {{24{ld_signed_i & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data_o = {{16{ld_signed_i & ld_half[15]}}, ld_half};
            default: ld_data_o = ld_rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_bus_initiator.sv
// Load/store bus initiator: turns a core load/store request into a single
// stb transaction, waits for ack/err (or times out) and returns extended
// read data with a one-cycle done pulse.
//   clk_i, rstn_i         : clock, synchronous active-low reset
//   req_i..wdata_i        : core request (sampled only while ready_o=1)
//   ready_o               : idle, request can be accepted
//   done_o                : completion pulse; rdata_o/err_o/err_cause_o valid
//   bus                   : single-stb/ack RAM bus, initiator side
module lsu_bus_initiator
    import jedro_1_defines::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [1:0]            size_i,
    input  logic                  signed_i,
    input  logic [DATA_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  ready_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o,
    output logic [1:0]            err_cause_o,
    lsu_bus_initiator_if.master   bus
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

    lsu_state_e            state_q;
    lsu_err_e              cause_q;
    logic                  we_q;
    logic [1:0]            size_q;
    logic                  signed_q;
    logic [1:0]            addr_lo_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  ready_q;
    logic                  done_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  stb_q;
    logic [NUM_BYTES-1:0]  bus_we_q;
    logic [DATA_WIDTH-1:0] bus_addr_q;
    logic [DATA_WIDTH-1:0] bus_wdata_q;

    logic [NUM_BYTES-1:0]  st_we;
    logic [DATA_WIDTH-1:0] st_wdata;
    logic [DATA_WIDTH-1:0] ld_data;

    lsu_lane_align u_lane_align (
        .st_size_i    (size_i),
        .st_addr_lo_i (addr_i[1:0]),
        .st_wdata_i   (wdata_i),
        .st_we_o      (st_we),
        .st_wdata_o   (st_wdata),
        .ld_size_i    (size_q),
        .ld_addr_lo_i (addr_lo_q),
        .ld_signed_i  (signed_q),
        .ld_rdata_i   (bus.rdata),
        .ld_data_o    (ld_data)
    );

    // FSM with registered outputs; stb and done default low so each is a single-cycle pulse.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q     <= LSU_IDLE;
            cause_q     <= ERR_NONE;
            we_q        <= 1'b0;
            size_q      <= SZ_BYTE;
            signed_q    <= 1'b0;
            addr_lo_q   <= '0;
            cnt_q       <= '0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            stb_q       <= 1'b0;
            bus_we_q    <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
        end else begin
            stb_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                LSU_IDLE: begin
                    if (req_i) begin
                        we_q      <= we_i;
                        size_q    <= size_i;
                        signed_q  <= signed_i;
                        addr_lo_q <= addr_i[1:0];
                        ready_q   <= 1'b0;
                        if (is_misaligned(size_i, addr_i[1:0])) begin
                            // Rejected before reaching the bus.
                            state_q <= LSU_RESP;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            cause_q <= ERR_MISALIGN;
                            rdata_q <= '0;
                        end else begin
                            // Bus outputs are loaded here so stb is visible during ISSUE.
                            state_q     <= LSU_ISSUE;
                            stb_q       <= 1'b1;
                            bus_we_q    <= we_i ? st_we : '0;
                            bus_addr_q  <= {addr_i[DATA_WIDTH-1:2], 2'b00};
                            bus_wdata_q <= st_wdata;
                        end
                    end
                end
                LSU_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= LSU_WAIT;
                end
                LSU_WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    // err outranks ack when both arrive together.
                    if (bus.err) begin
                        state_q  <= LSU_RESP;
                        done_q   <= 1'b1;
                        err_q    <= 1'b1;
                        cause_q  <= ERR_BUS;
                        rdata_q  <= '0;
                        bus_we_q <= '0;
                    end else if (bus.ack) begin
                        state_q  <= LSU_RESP;
                        done_q   <= 1'b1;
                        err_q    <= 1'b0;
                        cause_q  <= ERR_NONE;
                        rdata_q  <= we_q ? '0 : ld_data;
                        bus_we_q <= '0;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_q  <= LSU_RESP;
                        done_q   <= 1'b1;
                        err_q    <= 1'b1;
                        cause_q  <= ERR_TIMEOUT;
                        rdata_q  <= '0;
                        bus_we_q <= '0;
                    end
                end
                LSU_RESP: begin
                    state_q <= LSU_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= LSU_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready_o     = ready_q;
    assign done_o      = done_q;
    assign rdata_o     = rdata_q;
    assign err_o       = err_q;
    assign err_cause_o = cause_q;
    assign bus.stb     = stb_q;
    assign bus.we      = bus_we_q;
    assign bus.addr    = bus_addr_q;
    assign bus.wdata   = bus_wdata_q;

endmodule

// File: tb/tb_lsu_bus_initiator.sv
// Directed bench for lsu_bus_initiator with a queue-based scoreboard:
// requests push expected responses and bus transactions, independent
// monitors pop and compare on done_o and on stb.
module tb_lsu_bus_initiator;

    localparam int unsigned TO = 16;

    typedef struct {
        logic [1:0]  cause;
        logic [31:0] rdata;
    } resp_t;

    typedef struct {
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_t;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic        req_i;
    logic        we_i;
    logic [1:0]  size_i;
    logic        signed_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        ready_o;
    logic        done_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic [1:0]  err_cause_o;

    int total = 0;
    int bad   = 0;

    resp_t sb_q[$];
    bus_t  bus_q[$];

    int   mode  = 0;      // 0 normal, 1 never respond, 2 ack+err together
    logic stray = 1'b0;
    logic prev_stb = 1'b0;
    logic [31:0] mem [0:63];

    lsu_bus_initiator_if bus_if ();

    lsu_bus_initiator #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn_i),
        .req_i       (req_i),
        .we_i        (we_i),
        .size_i      (size_i),
        .signed_i    (signed_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .ready_o     (ready_o),
        .done_o      (done_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .err_cause_o (err_cause_o),
        .bus         (bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Zero-wait RAM responder.
    always @(posedge clk) begin
        bus_if.ack   <= 1'b0;
        bus_if.err   <= 1'b0;
        bus_if.rdata <= 32'h0;
        if (stray) begin
            bus_if.ack <= 1'b1;
            bus_if.err <= 1'b1;
        end else if (bus_if.stb) begin
            if (mode == 0) begin
                bus_if.ack   <= 1'b1;
                bus_if.rdata <= mem[bus_if.addr[7:2]];
                for (int b = 0; b < 4; b++)
                    if (bus_if.we[b]) mem[bus_if.addr[7:2]][8*b +: 8] <= bus_if.wdata[8*b +: 8];
            end else if (mode == 2) begin
                bus_if.ack   <= 1'b1;
                bus_if.err   <= 1'b1;
                bus_if.rdata <= 32'hFFFF_FFFF;
            end
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        resp_t e;
        if (done_o) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 want none, cause=%0d", err_cause_o);
            end else begin
                e = sb_q.pop_front();
                chk("rdata", rdata_o, e.rdata);
                chk("err", 32'(err_o), 32'(e.cause != 2'd0));
                chk("cause", 32'(err_cause_o), 32'(e.cause));
            end
        end
    end

    // Bus monitor.
    always @(negedge clk) begin
        bus_t e;
        if (bus_if.stb) begin
            if (prev_stb) begin
                total++;
                bad++;
                $display("FAIL stb_consecutive: got two stb cycles want one");
            end
            if (bus_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_stb: got stb addr=%h want none", bus_if.addr);
            end else begin
                e = bus_q.pop_front();
                chk("bus_we", 32'(bus_if.we), 32'(e.we));
                chk("bus_addr", bus_if.addr, e.addr);
                chk("bus_wdata", bus_if.wdata, e.wdata);
            end
        end
        prev_stb = bus_if.stb;
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) chk("ready_wait", 32'(ready_o), 32'd1);
    endtask

    task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] exp_cause, input logic [31:0] exp_rd,
                         input logic [3:0] exp_we, input logic [31:0] exp_wd,
                         input int exp_lat, input string nm);
        resp_t r;
        bus_t  b;
        int    lat;
        wait_ready();
        r.cause = exp_cause;
        r.rdata = exp_rd;
        sb_q.push_back(r);
        if (exp_cause != 2'd1) begin
            b.we    = exp_we;
            b.addr  = {a[31:2], 2'b00};
            b.wdata = exp_wd;
            bus_q.push_back(b);
        end
        req_i = 1'b1; we_i = w; size_i = sz; signed_i = sg; addr_i = a; wdata_i = wd;
        @(posedge clk);
        @(negedge clk);
        req_i = 1'b0;
        lat = 1;
        while (!done_o && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        rstn_i = 1'b0; req_i = 1'b0; we_i = 1'b0; size_i = 2'd0;
        signed_i = 1'b0; addr_i = 32'h0; wdata_i = 32'h0;
        repeat (3) @(negedge clk);

        // Reset state.
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_stb", 32'(bus_if.stb), 32'd0);
        chk("rst_we", 32'(bus_if.we), 32'd0);
        chk("rst_addr", bus_if.addr, 32'h0);
        chk("rst_wdata", bus_if.wdata, 32'h0);
        chk("rst_rdata", rdata_o, 32'h0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_cause", 32'(err_cause_o), 32'd0);
        rstn_i = 1'b1;

        // Word / byte / half stores and loads.
        issue(1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 2'd0, 32'h0,        4'b1111, 32'hDEADBEEF, 3, "st_word");
        issue(0, 2'd2, 0, 32'h100, 32'h0,        2'd0, 32'hDEADBEEF, 4'b0000, 32'h0,        3, "ld_word");
        issue(1, 2'd0, 0, 32'h103, 32'h000000A5, 2'd0, 32'h0,        4'b1000, 32'hA5A5A5A5, 3, "st_byte");
        issue(0, 2'd0, 1, 32'h103, 32'h0,        2'd0, 32'hFFFFFFA5, 4'b0000, 32'h0,        3, "ld_sbyte");
        issue(0, 2'd0, 0, 32'h103, 32'h0,        2'd0, 32'h000000A5, 4'b0000, 32'h0,        3, "ld_ubyte");
        issue(1, 2'd1, 0, 32'h102, 32'h00008001, 2'd0, 32'h0,        4'b1100, 32'h80018001, 3, "st_half");
        issue(0, 2'd1, 1, 32'h102, 32'h0,        2'd0, 32'hFFFF8001, 4'b0000, 32'h0,        3, "ld_shalf");
        issue(0, 2'd1, 1, 32'h100, 32'h0,        2'd0, 32'hFFFFBEEF, 4'b0000, 32'h0,        3, "ld_shalf_lo");
        issue(0, 2'd1, 0, 32'h100, 32'h0,        2'd0, 32'h0000BEEF, 4'b0000, 32'h0,        3, "ld_uhalf_lo");
        issue(0, 2'd0, 0, 32'h101, 32'h0,        2'd0, 32'h000000BE, 4'b0000, 32'h0,        3, "ld_ubyte1");
        issue(1, 2'd0, 0, 32'h101, 32'h00000077, 2'd0, 32'h0,        4'b0010, 32'h77777777, 3, "st_byte1");
        issue(0, 2'd2, 0, 32'h100, 32'h0,        2'd0, 32'h800177EF, 4'b0000, 32'h0,        3, "ld_word2");

        // Misaligned: no stb, done next cycle.
        issue(0, 2'd1, 1, 32'h101, 32'h0, 2'd1, 32'h0, 4'b0000, 32'h0, 1, "mis_half");
        issue(1, 2'd2, 0, 32'h102, 32'h1, 2'd1, 32'h0, 4'b0000, 32'h0, 1, "mis_word");
        issue(0, 2'd3, 0, 32'h100, 32'h0, 2'd1, 32'h0, 4'b0000, 32'h0, 1, "mis_size3");

        // Timeout, then stray acks are ignored, then normal operation.
        mode = 1;
        issue(0, 2'd2, 0, 32'h100, 32'h0, 2'd3, 32'h0, 4'b0000, 32'h0, 2 + TO, "timeout");
        mode = 0;
        @(negedge clk);
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        repeat (4) @(negedge clk);
        issue(0, 2'd2, 0, 32'h100, 32'h0, 2'd0, 32'h800177EF, 4'b0000, 32'h0, 3, "after_timeout");

        // err and ack together: bus error wins, rdata forced to 0.
        mode = 2;
        issue(0, 2'd2, 0, 32'h100, 32'h0,        2'd2, 32'h0, 4'b0000, 32'h0,        3, "ack_err_ld");
        issue(1, 2'd2, 0, 32'h104, 32'h12345678, 2'd2, 32'h0, 4'b1111, 32'h12345678, 3, "ack_err_st");
        mode = 0;

        // Reset while waiting: transaction dropped silently.
        mode = 1;
        wait_ready();
        begin
            bus_t b;
            b.we = 4'b0000; b.addr = 32'h100; b.wdata = 32'h0;
            bus_q.push_back(b);
        end
        req_i = 1'b1; we_i = 1'b0; size_i = 2'd2; signed_i = 1'b0; addr_i = 32'h100; wdata_i = 32'h0;
        @(posedge clk);
        @(negedge clk);
        req_i = 1'b0;
        chk("issue_ready", 32'(ready_o), 32'd0);
        @(negedge clk);
        rstn_i = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready", 32'(ready_o), 32'd1);
        chk("mid_rst_stb", 32'(bus_if.stb), 32'd0);
        chk("mid_rst_done", 32'(done_o), 32'd0);
        rstn_i = 1'b1;
        mode = 0;
        repeat (3) @(negedge clk);

        // Back-to-back requests.
        issue(1, 2'd2, 0, 32'h108, 32'hCAFEF00D, 2'd0, 32'h0,        4'b1111, 32'hCAFEF00D, 3, "b2b_st");
        issue(0, 2'd0, 1, 32'h10A, 32'h0,        2'd0, 32'hFFFFFFFE, 4'b0000, 32'h0,        3, "b2b_ld0");
        issue(0, 2'd1, 0, 32'h10A, 32'h0,        2'd0, 32'h0000CAFE, 4'b0000, 32'h0,        3, "b2b_ld1");

        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        chk("bus_empty", 32'(bus_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
